// File: rtl/flow_stream_aligner.sv
// flow_stream_aligner: delays NUM_CH streams by per-channel word counts so all
// channels line up on one pixel, delays SOF to the same point, and tracks the
// aligned pixel's x/y coordinate and border membership.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   en             - pixel enable; nothing advances while low
//   sof_in         - start of frame, coincident with channel 0 of pixel (0,0)
//   data_in        - NUM_CH packed words, channel i at [i*WORD_WIDTH +: WORD_WIDTH]
//   data_out       - aligned words, same packing (zero while invalid / in border)
//   valid_out      - all delay lines filled since reset
//   sof_out        - aligned start of frame
//   locked         - an aligned SOF has been seen since reset
//   x_out, y_out   - coordinate of the word on data_out
//   in_border      - word on data_out lies in the border
module flow_stream_aligner #(
  parameter int unsigned NUM_CH                = 3,
  parameter int unsigned WORD_WIDTH            = 12,
  parameter int unsigned FRAME_WIDTH           = 1280,
  parameter int unsigned FRAME_HEIGHT          = 720,
  parameter int unsigned MAX_DELAY             = 4095,
  parameter int unsigned CH_DELAY [NUM_CH]     = '{2562, 2557, 0},
  parameter int unsigned BORDER                = 3,
  parameter int unsigned BORDER_MODE           = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 en,
  input  logic                                 sof_in,
  input  logic [NUM_CH*WORD_WIDTH-1:0]         data_in,
  output logic [NUM_CH*WORD_WIDTH-1:0]         data_out,
  output logic                                 valid_out,
  output logic                                 sof_out,
  output logic                                 locked,
  output logic [$clog2(FRAME_WIDTH)-1:0]       x_out,
  output logic [$clog2(FRAME_HEIGHT)-1:0]      y_out,
  output logic                                 in_border
);

  function automatic int unsigned calc_d_max();
    int unsigned m;
    m = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (CH_DELAY[i] > m) m = CH_DELAY[i];
    end
    return m;
  endfunction

  localparam int unsigned W      = WORD_WIDTH;
  localparam int unsigned D_MAX  = calc_d_max();
  localparam int unsigned DEPTH  = MAX_DELAY + 1;
  localparam int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FILL_W = (D_MAX > 0) ? $clog2(D_MAX + 1) : 1;
  localparam int unsigned XW     = $clog2(FRAME_WIDTH);
  localparam int unsigned YW     = $clog2(FRAME_HEIGHT);

  // Circular read address: (wp - d) mod DEPTH without going negative.
  function automatic logic [AW-1:0] rd_addr(input logic [AW-1:0] wp, input int unsigned d);
    if (32'(wp) >= d) return AW'(32'(wp) - d);
    return AW'(32'(wp) + DEPTH - d);
  endfunction

  logic [AW-1:0]     wptr;
  logic [FILL_W-1:0] fill;
  logic [W-1:0]      ch_rd [NUM_CH];
  logic              sof_rd;

  // Per-channel delay lines; a zero delay bypasses the RAM entirely.
  for (genvar gi = 0; gi < int'(NUM_CH); gi++) begin : g_ch
    localparam int unsigned D = CH_DELAY[gi];
    if (D > MAX_DELAY) begin : g_bad
      $error("flow_stream_aligner: CH_DELAY[%0d]=%0d exceeds MAX_DELAY=%0d", gi, D, MAX_DELAY);
    end
    if (D == 0) begin : g_byp
      assign ch_rd[gi] = data_in[gi*W +: W];
    end else begin : g_ram
      logic [W-1:0] mem [DEPTH];
      always_ff @(posedge clk) begin
        if (en && !rst) mem[wptr] <= data_in[gi*W +: W];
      end
      assign ch_rd[gi] = mem[rd_addr(wptr, D)];
    end
  end

  // SOF marker line, delayed to the slowest channel.
  if (D_MAX == 0) begin : g_sof_byp
    assign sof_rd = sof_in;
  end else begin : g_sof_ram
    logic sof_mem [DEPTH];
    always_ff @(posedge clk) begin
      if (en && !rst) sof_mem[wptr] <= sof_in;
    end
    assign sof_rd = sof_mem[rd_addr(wptr, D_MAX)];
  end

  logic                       valid_n, sof_n, locked_n, border_n;
  logic [XW-1:0]              x_n;
  logic [YW-1:0]              y_n;
  logic [NUM_CH*W-1:0]        data_n;
  logic [AW-1:0]              wptr_n;
  logic [FILL_W-1:0]          fill_n;

  // Next-state for the outputs describing the word registered on this en cycle.
  always_comb begin
    wptr_n   = (32'(wptr) == MAX_DELAY) ? '0 : wptr + AW'(1);
    fill_n   = (32'(fill) == D_MAX) ? fill : fill + FILL_W'(1);
    valid_n  = (32'(fill) == D_MAX);
    sof_n    = valid_n && sof_rd;
    locked_n = locked;
    x_n      = x_out;
    y_n      = y_out;
    data_n   = '0;
    if (sof_n) begin
      locked_n = 1'b1;
      x_n      = '0;
      y_n      = '0;
    end else if (locked) begin
      if (32'(x_out) == FRAME_WIDTH - 1) begin
        x_n = '0;
        if (32'(y_out) != FRAME_HEIGHT - 1) y_n = y_out + YW'(1);
      end else begin
        x_n = x_out + XW'(1);
      end
    end
    border_n = !locked_n
            || (32'(x_n) < BORDER) || (32'(x_n) >= FRAME_WIDTH - BORDER)
            || (32'(y_n) < BORDER) || (32'(y_n) >= FRAME_HEIGHT - BORDER);
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (valid_n && !(BORDER_MODE == 0 && border_n)) data_n[i*W +: W] = ch_rd[i];
    end
  end

  // All state and outputs advance only on en; reset wins over en.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      fill      <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      sof_out   <= 1'b0;
      locked    <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      in_border <= 1'b1;
    end else if (en) begin
      wptr      <= wptr_n;
      fill      <= fill_n;
      data_out  <= data_n;
      valid_out <= valid_n;
      sof_out   <= sof_n;
      locked    <= locked_n;
      x_out     <= x_n;
      y_out     <= y_n;
      in_border <= border_n;
    end
  end

endmodule
